dequant_expand: RTL and testbench

Widening dequantizer that takes signed INPUT_DW-bit activations, applies a per-channel signed scale, and emits signed OUTPUT_DW-bit accumulator-domain values. It is the inverse end of the saturating narrowing stage: that stage squeezes accumulators into 8-bit activations, and this block re-expands them for the next layer's partial-sum path. It is a 2-stage valid/ready pipeline with a channel counter that selects the scale from a small writable register file.

---
 rtl/cu33_quant_pkg.sv | 22 ++
 rtl/dequant_scale_rf.sv | 36 +++
 rtl/dequant_expand.sv | 153 +++++++++++++++
 tb/tb_dequant_expand.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cu33_quant_pkg.sv
// Shared quantisation types and width helpers.
//   ACT_DW / SCALE_DW / ACC_DW : default activation, scale and accumulator widths
//   act_t / scale_t / acc_t    : signed data types at the default widths
//   width_ok()                 : true when an accumulator can hold (act+1)*scale exactly
package cu33_quant_pkg;

    localparam int unsigned ACT_DW   = 8;
    localparam int unsigned SCALE_DW = 8;
    localparam int unsigned ACC_DW   = 24;

    typedef logic signed [ACT_DW-1:0]   act_t;
    typedef logic signed [SCALE_DW-1:0] scale_t;
    typedef logic signed [ACC_DW-1:0]   acc_t;

    // The widened difference needs one extra bit; the product then needs the scale width on top.
    function automatic bit width_ok(input int unsigned in_dw,
                                    input int unsigned scale_dw,
                                    input int unsigned out_dw);
        return out_dw >= (in_dw + 1 + scale_dw);
    endfunction

endpackage

// File: rtl/dequant_scale_rf.sv
// Per-channel signed scale register file.
//   clk, rst     : clock, asynchronous active-high reset (all entries reset to 1)
//   wr_en_i      : write strobe for wr_addr_i / wr_data_i
//   rd_addr_i    : read index
//   rd_data_o    : combinational read data (reflects writes from the next cycle on)
module dequant_scale_rf
    import cu33_quant_pkg::*;
#(
    parameter int unsigned DW = SCALE_DW,
    parameter int unsigned N  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en_i,
    input  logic [$clog2(N)-1:0]       wr_addr_i,
    input  logic signed [DW-1:0]       wr_data_i,
    input  logic [$clog2(N)-1:0]       rd_addr_i,
    output logic signed [DW-1:0]       rd_data_o
);

    logic signed [DW-1:0] rf_q [N];

    // Storage: identity scale out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(N); i++) begin
                rf_q[i] <= DW'(1);
            end
        end else if (wr_en_i) begin
            rf_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = rf_q[rd_addr_i];

endmodule

// File: rtl/dequant_expand.sv
// Widening dequantizer: out = sext((in - zp) * scale[ch]), 2-stage valid/ready pipeline.
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid/in_ready   : input handshake (in_ready is combinational from out_ready)
//   in_data             : signed activation
//   ch_clr              : restart channel sequence at 0
//   cfg_we/addr/scale   : scale register write port
//   zp                  : signed zero point, only with DEQUANT_ZP_EN defined
//   out_valid/out_ready : output handshake
//   out_data, out_ch    : registered signed result and its channel tag
// Build option: DEQUANT_ZP_EN adds the zp port and subtracts it in stage 1.
module dequant_expand #(
    parameter int unsigned INPUT_DW  = cu33_quant_pkg::ACT_DW,
    parameter int unsigned SCALE_DW  = cu33_quant_pkg::SCALE_DW,
    parameter int unsigned OUTPUT_DW = cu33_quant_pkg::ACC_DW,
    parameter int unsigned NUM_CH    = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic signed [INPUT_DW-1:0]    in_data,
    input  logic                          ch_clr,
    input  logic                          cfg_we,
    input  logic [$clog2(NUM_CH)-1:0]     cfg_addr,
    input  logic signed [SCALE_DW-1:0]    cfg_scale,
`ifdef DEQUANT_ZP_EN
    input  logic signed [INPUT_DW-1:0]    zp,
`endif
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic signed [OUTPUT_DW-1:0]   out_data,
    output logic [$clog2(NUM_CH)-1:0]     out_ch
);

    localparam int unsigned CH_W   = $clog2(NUM_CH);
    localparam int unsigned DIFF_W = INPUT_DW + 1;
    localparam int unsigned PROD_W = DIFF_W + SCALE_DW;

    // Elaboration guards: the product must fit without saturation, and the counter needs 2+ channels.
    if (!cu33_quant_pkg::width_ok(INPUT_DW, SCALE_DW, OUTPUT_DW)) begin : g_bad_width
        $error("dequant_expand: OUTPUT_DW too narrow for INPUT_DW+1+SCALE_DW");
    end
    if (NUM_CH < 2) begin : g_bad_num_ch
        $error("dequant_expand: NUM_CH must be at least 2");
    end

    logic [CH_W-1:0]            ch_q, ch_d;
    logic [CH_W-1:0]            tag_ch_c;
    logic                       accept_c;
    logic                       s2_load_c;
    logic signed [DIFF_W-1:0]   diff_c;
    logic signed [SCALE_DW-1:0] rf_scale_c;
    logic signed [PROD_W-1:0]   prod_c;

    logic                       s1_valid_q, s1_valid_d;
    logic signed [DIFF_W-1:0]   s1_diff_q, s1_diff_d;
    logic signed [SCALE_DW-1:0] s1_scale_q, s1_scale_d;
    logic [CH_W-1:0]            s1_ch_q, s1_ch_d;

    logic                       s2_valid_q, s2_valid_d;
    logic signed [OUTPUT_DW-1:0] s2_data_q, s2_data_d;
    logic [CH_W-1:0]            s2_ch_q, s2_ch_d;

    // Scale lookup is indexed by the tag the current beat will carry, so ch_clr takes effect immediately.
    dequant_scale_rf #(
        .DW (SCALE_DW),
        .N  (NUM_CH)
    ) u_scale_rf (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (cfg_we),
        .wr_addr_i (cfg_addr),
        .wr_data_i (cfg_scale),
        .rd_addr_i (tag_ch_c),
        .rd_data_o (rf_scale_c)
    );

    // Handshake, channel counter and both stage next-states.
    always_comb begin
        s2_load_c = !s2_valid_q || out_ready;
        in_ready  = !s1_valid_q || s2_load_c;
        accept_c  = in_valid && in_ready;
        tag_ch_c  = ch_clr ? '0 : ch_q;

`ifdef DEQUANT_ZP_EN
        diff_c = DIFF_W'(in_data) - DIFF_W'(zp);
`else
        diff_c = DIFF_W'(in_data);
`endif

        ch_d = ch_q;
        if (accept_c) begin
            ch_d = (tag_ch_c == CH_W'(NUM_CH - 1)) ? '0 : tag_ch_c + CH_W'(1);
        end else if (ch_clr) begin
            ch_d = '0;
        end

        s1_valid_d = s1_valid_q;
        s1_diff_d  = s1_diff_q;
        s1_scale_d = s1_scale_q;
        s1_ch_d    = s1_ch_q;
        if (in_ready) begin
            s1_valid_d = in_valid;
        end
        if (accept_c) begin
            s1_diff_d  = diff_c;
            s1_scale_d = rf_scale_c;
            s1_ch_d    = tag_ch_c;
        end

        // Both operands widened to the full product width; exact by the width rule.
        prod_c = PROD_W'(s1_diff_q) * PROD_W'(s1_scale_q);

        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        s2_ch_d    = s2_ch_q;
        if (s2_load_c) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_data_d = OUTPUT_DW'(prod_c);
                s2_ch_d   = s1_ch_q;
            end
        end
    end

    // Pipeline and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ch_q       <= '0;
            s1_valid_q <= 1'b0;
            s1_diff_q  <= '0;
            s1_scale_q <= '0;
            s1_ch_q    <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_ch_q    <= '0;
        end else begin
            ch_q       <= ch_d;
            s1_valid_q <= s1_valid_d;
            s1_diff_q  <= s1_diff_d;
            s1_scale_q <= s1_scale_d;
            s1_ch_q    <= s1_ch_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            s2_ch_q    <= s2_ch_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_data  = s2_data_q;
    assign out_ch    = s2_ch_q;

endmodule

// File: tb/tb_dequant_expand.sv
// Randomised self-checking bench for dequant_expand against an in-order queue model.
module tb_dequant_expand;

    localparam int unsigned INPUT_DW  = 8;
    localparam int unsigned SCALE_DW  = 8;
    localparam int unsigned OUTPUT_DW = 24;
    localparam int unsigned NUM_CH    = 16;
    localparam int unsigned CH_W      = $clog2(NUM_CH);

    logic                         clk = 1'b0;
    logic                         rst;
    logic                         in_valid;
    logic                         in_ready;
    logic signed [INPUT_DW-1:0]   in_data;
    logic                         ch_clr;
    logic                         cfg_we;
    logic [CH_W-1:0]              cfg_addr;
    logic signed [SCALE_DW-1:0]   cfg_scale;
`ifdef DEQUANT_ZP_EN
    logic signed [INPUT_DW-1:0]   zp;
`endif
    logic                         out_valid;
    logic                         out_ready;
    logic signed [OUTPUT_DW-1:0]  out_data;
    logic [CH_W-1:0]              out_ch;

    dequant_expand #(
        .INPUT_DW  (INPUT_DW),
        .SCALE_DW  (SCALE_DW),
        .OUTPUT_DW (OUTPUT_DW),
        .NUM_CH    (NUM_CH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .ch_clr    (ch_clr),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_scale (cfg_scale),
`ifdef DEQUANT_ZP_EN
        .zp        (zp),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ch    (out_ch)
    );

    always #5 clk = ~clk;

    typedef struct {
        int data;
        int ch;
        int age;
    } exp_t;

    int   errors = 0;
    int   checks = 0;
    int   scale_m [NUM_CH];
    int   ch_m;
    exp_t q [$];

    task automatic check(input string tag, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        ch_m = 0;
        for (int i = 0; i < int'(NUM_CH); i++) scale_m[i] = 1;
    endtask

    // Called just after a negedge with inputs driven; advances one full clock.
    task automatic tick(output bit acc);
        bit   pop;
        int   tag;
        int   zpv;
        exp_t e;
        #1;
        acc = in_valid && in_ready;
        pop = out_valid && out_ready;
        // Two beats in flight means both stages hold data; only then can the input stall.
        check("in_ready", int'(in_ready), int'((q.size() < 2) || out_ready));
        // The oldest beat reaches the output one edge after it was accepted.
        check("out_valid", int'(out_valid), int'(q.size() > 0 && q[0].age >= 1));
        if (out_valid && q.size() > 0) begin
            check("out_data", int'(out_data), q[0].data);
            check("out_ch", int'(out_ch), q[0].ch);
        end
`ifdef DEQUANT_ZP_EN
        zpv = int'(zp);
`else
        zpv = 0;
`endif
        if (acc) begin
            tag  = ch_clr ? 0 : ch_m;
            e    = '{(int'(in_data) - zpv) * scale_m[tag], tag, 0};
            ch_m = (tag + 1) % int'(NUM_CH);
        end else if (ch_clr) begin
            ch_m = 0;
        end
        if (cfg_we) scale_m[int'(cfg_addr)] = int'(cfg_scale);
        @(posedge clk);
        if (pop && q.size() > 0) void'(q.pop_front());
        foreach (q[i]) q[i].age++;
        if (acc) q.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        bit a;
        in_valid = 1'b0;
        repeat (n) tick(a);
    endtask

    task automatic beat(input int v, input bit clr);
        bit a;
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_data  = INPUT_DW'(v);
        ch_clr   = clr;
        for (int n = 0; n < 50 && !done; n++) begin
            tick(a);
            done = a;
        end
        if (!done) check("accept_timeout", 0, 1);
        in_valid = 1'b0;
        ch_clr   = 1'b0;
    endtask

    task automatic cfg(input int addr, input int val);
        bit a;
        in_valid  = 1'b0;
        cfg_we    = 1'b1;
        cfg_addr  = CH_W'(addr);
        cfg_scale = SCALE_DW'(val);
        tick(a);
        cfg_we    = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit a;
        int v;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        ch_clr    = 1'b0;
        cfg_we    = 1'b0;
        cfg_addr  = '0;
        cfg_scale = '0;
        out_ready = 1'b1;
`ifdef DEQUANT_ZP_EN
        zp        = '0;
`endif
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_out_ch", int'(out_ch), 0);
        check("rst_in_ready", int'(in_ready), 1);
        @(negedge clk);
        rst = 1'b0;

        // Identity scales, extreme and zero inputs.
        beat(127, 1'b0);
        beat(-128, 1'b0);
        beat(0, 1'b0);
        idle(4);

        // Negative and positive scale extremes on channel 0.
        cfg(0, -128);
        beat(-128, 1'b1);
        idle(3);
        cfg(0, 127);
        beat(-128, 1'b1);
        idle(3);
`ifdef DEQUANT_ZP_EN
        zp = -8'sd128;
        beat(127, 1'b1);
        idle(3);
        zp = '0;
`endif

        // Scale write and accept in the same cycle: beat must see the old scale.
        in_valid  = 1'b1;
        in_data   = 8'sd3;
        ch_clr    = 1'b1;
        cfg_we    = 1'b1;
        cfg_addr  = '0;
        cfg_scale = 8'sd5;
        tick(a);
        cfg_we = 1'b0;
        ch_clr = 1'b0;
        idle(3);

        // Five-cycle output stall mid-stream.
        v        = 10;
        in_valid = 1'b1;
        in_data  = INPUT_DW'(v);
        ch_clr   = 1'b1;
        for (int c = 0; c < 30 && v < 18; c++) begin
            out_ready = !(c >= 2 && c < 7);
            tick(a);
            ch_clr = 1'b0;
            if (a) begin
                v++;
                in_data = INPUT_DW'(v);
            end
        end
        out_ready = 1'b1;
        idle(4);

        // Counter wrap, then ch_clr coinciding with beat 5.
        for (int i = 0; i < int'(NUM_CH) + 2; i++) beat(i * 3 - 20, i == 0);
        for (int i = 0; i < 8; i++) beat(i + 40, i == 5);
        ch_clr = 1'b1;
        idle(1);
        ch_clr = 1'b0;
        beat(7, 1'b0);
        idle(3);

        // Random traffic with configuration writes and clears.
        for (int c = 0; c < 600; c++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            in_data   = INPUT_DW'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            ch_clr    = ($urandom_range(0, 19) == 0);
            cfg_we    = ($urandom_range(0, 9) == 0);
            cfg_addr  = CH_W'($urandom);
            cfg_scale = SCALE_DW'($urandom);
`ifdef DEQUANT_ZP_EN
            zp        = INPUT_DW'($urandom);
`endif
            tick(a);
        end
        in_valid  = 1'b0;
        ch_clr    = 1'b0;
        cfg_we    = 1'b0;
        out_ready = 1'b1;
`ifdef DEQUANT_ZP_EN
        zp        = '0;
`endif
        idle(4);

        // Reset with both stages full.
        cfg(2, -3);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'sd21;
        tick(a);
        in_data   = 8'sd22;
        tick(a);
        in_valid  = 1'b0;
        check("full_before_rst", q.size(), 2);
        rst = 1'b1;
        #1;
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_out_data", int'(out_data), 0);
        check("midrst_out_ch", int'(out_ch), 0);
        model_reset();
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b1;
        beat(5, 1'b0);
        beat(6, 1'b0);
        beat(9, 1'b0);
        idle(5);

        check("drain_empty", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
